// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: tick and raw pin in, clean level and event pulses out.
interface button_debouncer_if;
    logic slow_clk_en;
    logic btn_raw;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;

    modport master (
        output slow_clk_en,
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  slow_clk_en,
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes a raw pin, samples it on slow ticks, and
// produces a clean level plus one-cycle press, release and long-press pulses.
module button_debouncer #(
    parameter int STABLE_TICKS   = 4,
    parameter int HOLD_TICKS     = 200,
    parameter bit BTN_ACTIVE_LOW = 1'b0
) (
    input  logic                Clk_100M,
    input  logic                pushButton_1,
    button_debouncer_if.slave   btn_if
);

    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic          RELEASED_LVL = BTN_ACTIVE_LOW;
    localparam logic [SW-1:0] STAB_ONE     = SW'(1);
    localparam logic [SW-1:0] STAB_LAST    = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX     = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          pressed;

    state_t        state_q,    state_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          level_q,    level_d;
    logic          press_q,    press_d;
    logic          release_q,  release_d;
    logic          long_q,     long_d;

    // Two-flop synchronizer; reset loads the released pin level so no false press appears.
    always_ff @(posedge Clk_100M or negedge pushButton_1) begin
        if (!pushButton_1) begin
            sync1_q <= RELEASED_LVL;
            sync2_q <= RELEASED_LVL;
        end else begin
            sync1_q <= btn_if.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ RELEASED_LVL;

    // Next-state logic: everything advances only on tick cycles; pulses default low.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;

        if (btn_if.slow_clk_en) begin
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_d    = PRESS_CHK;
                        stab_cnt_d = STAB_ONE;
                    end
                end

                PRESS_CHK: begin
                    if (!pressed) begin
                        state_d    = IDLE;
                        stab_cnt_d = '0;
                    end else if (stab_cnt_q == STAB_LAST) begin
                        state_d    = PRESSED;
                        stab_cnt_d = '0;
                        hold_cnt_d = '0;
                        level_d    = 1'b1;
                        press_d    = 1'b1;
                    end else begin
                        stab_cnt_d = stab_cnt_q + STAB_ONE;
                    end
                end

                PRESSED: begin
                    if (!pressed) begin
                        state_d    = RELEASE_CHK;
                        stab_cnt_d = STAB_ONE;
                    end else if (hold_cnt_q < HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                        long_d     = (hold_cnt_q == HOLD_LAST);
                    end
                end

                RELEASE_CHK: begin
                    if (pressed) begin
                        state_d    = PRESSED;
                        stab_cnt_d = '0;
                    end else if (stab_cnt_q == STAB_LAST) begin
                        state_d    = IDLE;
                        stab_cnt_d = '0;
                        level_d    = 1'b0;
                        release_d  = 1'b1;
                    end else begin
                        stab_cnt_d = stab_cnt_q + STAB_ONE;
                    end
                end

                default: begin
                    state_d    = IDLE;
                    stab_cnt_d = '0;
                    hold_cnt_d = '0;
                    level_d    = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs; reset discards any debounce progress.
    always_ff @(posedge Clk_100M or negedge pushButton_1) begin
        if (!pushButton_1) begin
            state_q    <= IDLE;
            stab_cnt_q <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign btn_if.btn_level   = level_q;
    assign btn_if.btn_press   = press_q;
    assign btn_if.btn_release = release_q;
    assign btn_if.btn_long    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_TICKS=4, HOLD_TICKS=8 and a tick every 10 clocks.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rstN;

    button_debouncer_if bif ();

    button_debouncer #(
        .STABLE_TICKS   (4),
        .HOLD_TICKS     (8),
        .BTN_ACTIVE_LOW (1'b0)
    ) dut (
        .Clk_100M     (clk),
        .pushButton_1 (rstN),
        .btn_if       (bif)
    );

    int   checks = 0;
    int   errors = 0;
    int   phase  = 0;
    bit   tieHigh = 1'b0;
    bit   tickTaken;
    int   pressCount;
    int   releaseCount;
    int   longCount;
    bit   overlapSeen = 1'b0;
    bit   levelGlitch = 1'b0;
    bit   resetLeak   = 1'b0;
    logic prevLevel   = 1'b0;

    // 100 MHz clock
    always #5 clk = ~clk;

    // Global time limit so the bench can never hang
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clearCounts();
        pressCount   = 0;
        releaseCount = 0;
        longCount    = 0;
    endtask

    // One clock: sample outputs after the edge, track pulse history, schedule the next tick
    task automatic applyStimulus();
        int pulses;
        @(posedge clk);
        tickTaken = bif.slow_clk_en;
        #1;
        pulses = int'(bif.btn_press) + int'(bif.btn_release) + int'(bif.btn_long);
        pressCount   += int'(bif.btn_press);
        releaseCount += int'(bif.btn_release);
        longCount    += int'(bif.btn_long);
        if (pulses > 1) overlapSeen = 1'b1;
        if (bif.btn_level !== prevLevel) begin
            if (bif.btn_level === 1'b1 && bif.btn_press !== 1'b1) levelGlitch = 1'b1;
            if (bif.btn_level === 1'b0 && bif.btn_release !== 1'b1) levelGlitch = 1'b1;
        end
        prevLevel = bif.btn_level;
        if (rstN === 1'b0 && (bif.btn_level | pulses != 0)) resetLeak = 1'b1;
        phase = (phase + 1) % 10;
        bif.slow_clk_en = tieHigh || (phase == 0);
    endtask

    // Advance until n ticks have been consumed by the DUT, bounded by a cycle budget
    task automatic runTicks(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 20 * n + 20) begin
            applyStimulus();
            if (tickTaken) seen++;
            cyc++;
        end
        checkOutput("tick_budget", seen, n);
    endtask

    initial begin
        rstN            = 1'b0;
        bif.btn_raw     = 1'b1;
        bif.slow_clk_en = 1'b0;
        clearCounts();

        // 1: reset held with the button pressed and ticks running
        repeat (30) applyStimulus();
        checkOutput("reset_quiet", resetLeak, 0);
        checkOutput("reset_level", bif.btn_level, 0);
        runTicks(1);
        rstN = 1'b1;
        clearCounts();
        runTicks(3);
        checkOutput("rst_rel_no_early_press", pressCount, 0);
        checkOutput("rst_rel_level_early", bif.btn_level, 0);
        runTicks(1);
        checkOutput("rst_rel_level", bif.btn_level, 1);
        checkOutput("rst_rel_press", bif.btn_press, 1);
        bif.btn_raw = 1'b0;
        clearCounts();
        runTicks(3);
        checkOutput("rst_rel_hold_level", bif.btn_level, 1);
        runTicks(1);
        checkOutput("rst_rel_release", bif.btn_release, 1);
        checkOutput("rst_rel_no_long", longCount, 0);

        // 2: clean press, hold for 20 ticks, release
        bif.btn_raw = 1'b1;
        clearCounts();
        runTicks(3);
        checkOutput("press_level_early", bif.btn_level, 0);
        runTicks(1);
        checkOutput("press_level", bif.btn_level, 1);
        checkOutput("press_pulse", bif.btn_press, 1);
        applyStimulus();
        checkOutput("press_pulse_end", bif.btn_press, 0);
        runTicks(7);
        checkOutput("long_not_early", longCount, 0);
        runTicks(1);
        checkOutput("long_pulse", bif.btn_long, 1);
        runTicks(8);
        checkOutput("long_once", longCount, 1);
        checkOutput("press_once", pressCount, 1);
        bif.btn_raw = 1'b0;
        runTicks(3);
        checkOutput("release_level_early", bif.btn_level, 1);
        runTicks(1);
        checkOutput("release_pulse", bif.btn_release, 1);
        checkOutput("release_level", bif.btn_level, 0);
        applyStimulus();
        checkOutput("release_pulse_end", bif.btn_release, 0);
        checkOutput("release_once", releaseCount, 1);

        // 3: bounce every 15 clocks for 60 clocks
        runTicks(1);
        clearCounts();
        for (int i = 0; i < 60; i++) begin
            if (i % 15 == 0) bif.btn_raw = ~bif.btn_raw;
            applyStimulus();
        end
        runTicks(2);
        checkOutput("bounce_level", bif.btn_level, 0);
        checkOutput("bounce_pulses", pressCount + releaseCount + longCount, 0);

        // 4: three-clock glitch between ticks
        runTicks(1);
        clearCounts();
        repeat (3) applyStimulus();
        bif.btn_raw = 1'b1;
        repeat (3) applyStimulus();
        bif.btn_raw = 1'b0;
        runTicks(4);
        checkOutput("glitch_level", bif.btn_level, 0);
        checkOutput("glitch_pulses", pressCount + releaseCount + longCount, 0);

        // 5: one-tick release glitch while pressed
        bif.btn_raw = 1'b1;
        runTicks(4);
        checkOutput("rg_press", bif.btn_level, 1);
        clearCounts();
        bif.btn_raw = 1'b0;
        runTicks(1);
        bif.btn_raw = 1'b1;
        runTicks(1);
        checkOutput("rg_level", bif.btn_level, 1);
        runTicks(7);
        checkOutput("rg_long_not_early", longCount, 0);
        runTicks(1);
        checkOutput("rg_long_hold_kept", bif.btn_long, 1);
        checkOutput("rg_no_release", releaseCount, 0);
        checkOutput("rg_no_repress", pressCount, 0);

        // 6: reset while pressed, released with the button still held
        rstN = 1'b0;
        #1;
        checkOutput("midrst_async_level", bif.btn_level, 0);
        prevLevel = 1'b0;
        resetLeak = 1'b0;
        repeat (15) applyStimulus();
        runTicks(1);
        rstN = 1'b1;
        clearCounts();
        runTicks(3);
        checkOutput("midrst_no_early_press", pressCount, 0);
        runTicks(1);
        checkOutput("midrst_press", bif.btn_press, 1);
        checkOutput("midrst_level", bif.btn_level, 1);
        checkOutput("midrst_quiet", resetLeak, 0);
        bif.btn_raw = 1'b0;
        runTicks(4);
        checkOutput("midrst_release", bif.btn_level, 0);

        // Extra: tick tied high, every cycle samples the pin
        tieHigh = 1'b1;
        bif.slow_clk_en = 1'b1;
        clearCounts();
        bif.btn_raw = 1'b1;
        repeat (5) applyStimulus();
        checkOutput("tie_no_early_press", pressCount, 0);
        applyStimulus();
        checkOutput("tie_press", bif.btn_press, 1);
        checkOutput("tie_level", bif.btn_level, 1);
        repeat (7) applyStimulus();
        checkOutput("tie_long_not_early", longCount, 0);
        applyStimulus();
        checkOutput("tie_long", bif.btn_long, 1);
        bif.btn_raw = 1'b0;
        repeat (5) applyStimulus();
        checkOutput("tie_release_early", releaseCount, 0);
        applyStimulus();
        checkOutput("tie_release", bif.btn_release, 1);
        checkOutput("tie_release_level", bif.btn_level, 0);

        // Whole-run invariants
        checkOutput("pulse_exclusive", overlapSeen, 0);
        checkOutput("level_with_pulse", levelGlitch, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
